// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Program loader on the write side of the instruction fetch path. It accepts
//   a framed byte stream and assembles big-endian 32-bit words. The words are
//   written to consecutive instruction-memory addresses starting at 0. The
//   processor is held in reset until the whole image is written and its XOR
//   checksum matches.
//
//   Frame: COUNT_HI, COUNT_LO (word count N), N*4 payload bytes (each word MSB
//   first), then CHK = XOR of every preceding byte of the frame.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   in_valid     in_data holds a byte
//   in_data      stream byte
//   in_ready     loader accepts a byte this cycle
//   restart      single-cycle pulse, honoured only in DONE or ERROR
//   mem_we       instruction-memory write strobe, one cycle per word
//   mem_addr     word address of the write
//   mem_wdata    word to write
//   cpu_rst      processor reset, active-high, released only on a good load
//   done         image loaded and checksum matched
//   error        load rejected
//   words_loaded words written in the current load
// -----------------------------------------------------------------------------
module instr_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  restart,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        ST_HDR_HI = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    // Largest legal word count: the full memory depth.
    localparam logic [16:0]         MAX_WORDS_C = 17'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] WORD_ONE_C  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Running checksum update step.
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t                  state_r;
    state_t                  next_state_s;
    logic                    accept_s;
    logic [16:0]             n_full_s;
    logic                    last_byte_s;

    logic [7:0]              count_hi_r;
    logic [ADDR_WIDTH:0]     n_r;
    logic [7:0]              xor_r;
    logic [1:0]              lane_r;
    logic [DATA_WIDTH-9:0]   shift_r;
    logic                    mem_we_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [DATA_WIDTH-1:0]   mem_wdata_r;
    logic [ADDR_WIDTH:0]     words_loaded_r;
    logic                    in_ready_r;
    logic                    cpu_rst_r;
    logic                    done_r;
    logic                    error_r;

    assign in_ready     = in_ready_r;
    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign cpu_rst      = cpu_rst_r;
    assign done         = done_r;
    assign error        = error_r;
    assign words_loaded = words_loaded_r;

    // Handshake, full word count and last-payload-byte decode.
    always_comb begin
        accept_s    = in_valid && in_ready_r;
        n_full_s    = {1'b0, count_hi_r, in_data};
        // words_loaded_r still counts the words completed before this byte.
        last_byte_s = (lane_r == 2'd3) && ((words_loaded_r + WORD_ONE_C) == n_r);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_HDR_HI;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_HDR_HI: begin
                if (accept_s) begin
                    next_state_s = ST_HDR_LO;
                end else begin
                    next_state_s = ST_HDR_HI;
                end
            end
            ST_HDR_LO: begin
                if (!accept_s) begin
                    next_state_s = ST_HDR_LO;
                end else if (n_full_s > MAX_WORDS_C) begin
                    next_state_s = ST_ERROR;
                end else if (n_full_s == 17'd0) begin
                    next_state_s = ST_CHECK;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept_s && last_byte_s) begin
                    next_state_s = ST_CHECK;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_CHECK: begin
                if (!accept_s) begin
                    next_state_s = ST_CHECK;
                end else if (in_data == xor_r) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_ERROR;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (restart) begin
                    next_state_s = ST_HDR_HI;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s = ST_HDR_HI;
            end
        endcase
    end

    // Status outputs, registered from the next state so they change with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_r <= 1'b1;
            cpu_rst_r  <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            in_ready_r <= (next_state_s != ST_DONE) && (next_state_s != ST_ERROR);
            cpu_rst_r  <= (next_state_s != ST_DONE);
            done_r     <= (next_state_s == ST_DONE);
            error_r    <= (next_state_s == ST_ERROR);
        end
    end

    // Header capture, checksum, word assembly and memory write strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_hi_r     <= 8'd0;
            n_r            <= '0;
            xor_r          <= 8'd0;
            lane_r         <= 2'd0;
            shift_r        <= '0;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= '0;
            mem_wdata_r    <= '0;
            words_loaded_r <= '0;
        end else begin
            mem_we_r <= 1'b0;
            case (state_r)
                ST_HDR_HI: begin
                    if (accept_s) begin
                        count_hi_r <= in_data;
                        xor_r      <= chk_fold(xor_r, in_data);
                    end
                end
                ST_HDR_LO: begin
                    if (accept_s) begin
                        // Only meaningful when the count is legal; an
                        // over-length count goes straight to ERROR.
                        n_r   <= n_full_s[ADDR_WIDTH:0];
                        xor_r <= chk_fold(xor_r, in_data);
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        xor_r  <= chk_fold(xor_r, in_data);
                        lane_r <= lane_r + 2'd1;
                        if (lane_r == 2'd3) begin
                            mem_wdata_r    <= {shift_r, in_data};
                            mem_addr_r     <= words_loaded_r[ADDR_WIDTH-1:0];
                            mem_we_r       <= 1'b1;
                            words_loaded_r <= words_loaded_r + WORD_ONE_C;
                        end else begin
                            shift_r <= {shift_r[DATA_WIDTH-17:0], in_data};
                        end
                    end
                end
                ST_DONE, ST_ERROR: begin
                    if (restart) begin
                        words_loaded_r <= '0;
                        lane_r         <= 2'd0;
                        xor_r          <= 8'd0;
                    end
                end
                default: begin
                    // CHECK only compares; nothing to update here.
                end
            endcase
        end
    end

endmodule
